adc_capture_buffer: RTL and testbench
=====================================

// Module: adc_capture_buffer
// PURPOSE
//  Triggered capture stage between an RFSoC ADC AXI-stream (128-bit, 8x16-bit samples/beat) and the GPIO readback path.
//  Once armed and triggered, skips a programmable number of beats, then stores a programmable number of beats in a FWFT FIFO.
//  The FIFO drains over a valid/ready port that feeds the GPIO reader's mac_adc/nl_adc inputs (one instance per ADC channel).
// PARAMETERS
//  DATA_W   128  width of one ADC beat
//  DEPTH    16   FIFO depth in beats, power of 2, >=2
//  CNT_W    16   width of delay/length counters
// PORTS
//  clk           in   1        system clock; sole clock domain
//  rst           in   1        synchronous reset, active-low
//  adc_data_in   in   DATA_W   ADC beat
//  adc_valid_in  in   1        beat qualifier; no backpressure to the ADC
//  arm           in   1        one-cycle pulse: latch delay/length, enter ARMED
//  trigger       in   1        level; sampled only in ARMED
//  flush         in   1        one-cycle pulse: abort capture, empty FIFO, clear overflow
//  delay_len     in   CNT_W    valid beats to skip after trigger
//  capture_len   in   CNT_W    valid beats to capture
//  out_data      out  DATA_W   FIFO head (FWFT)
//  out_valid     out  1        FIFO not empty
//  out_ready     in   1        consumer pop; pop = out_valid & out_ready
//  busy          out  1        state is ARMED, DELAY or CAPTURE
//  done          out  1        state is DONE
//  overflow      out  1        sticky: >=1 capture beat dropped (FIFO full)
//  level         out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE; FIFO empty; out_valid=0, busy=0, done=0, overflow=0, level=0; out_data=0.
//  States: IDLE, ARMED, DELAY, CAPTURE, DONE.
//  - IDLE/DONE + arm: latch delay_len and capture_len -> ARMED. arm in ARMED/DELAY/CAPTURE is ignored.
//  - ARMED + trigger==1: delay!=0 -> DELAY; delay==0 & len!=0 -> CAPTURE; len==0 -> DONE.
//    The beat in the trigger cycle is never stored.
//  - DELAY: count adc_valid_in beats. After the delay_len-th beat -> CAPTURE, or DONE if len==0.
//    That last skipped beat is not stored.
//  - CAPTURE: every adc_valid_in beat is a push attempt and increments the captured count.
//    After the capture_len-th attempt -> DONE. That beat is pushed in the same cycle.
//  - DONE: holds until the next arm. FIFO contents are kept until drained.
//  - The FIFO is not cleared by arm. Only flush or rst empties it.
//  FIFO:
//  - Push accepted if level<DEPTH, or if a pop occurs in the same cycle.
//  - A rejected push sets overflow. The count still advances, so capture timing stays fixed.
//  - Pop and push in the same cycle: level unchanged; data order preserved.
//  - out_data is valid whenever out_valid=1 and is stable until popped.
//  - Latency: a pushed beat appears at out_data/out_valid the cycle after the push edge (1 cycle).
//  - Pointers wrap modulo DEPTH. level saturates logically at DEPTH; never exceeds it.
//  Flush:
//  - State -> IDLE, level=0, overflow=0.
//  - Takes priority over arm, push and pop in the same cycle.
//  - flush and arm together: flush wins; arm is dropped.
//  - rst has priority over everything.
//  - Reset or flush mid-CAPTURE discards the partial capture. No partial-count status is kept.
//  Arithmetic: counters are CNT_W unsigned, compared for equality with the latched values. No wrap is possible inside one capture.
// TESTING
//  1. arm(delay=0,len=4), trigger, 6 valid beats D0..D5, out_ready=1 -> D1..D4 out in order; done=1; overflow=0.
//  2. arm(delay=3,len=2), trigger, beats D0..D6 -> FIFO holds D4,D5; level=2; busy falls the cycle after D5.
//  3. DEPTH=16, out_ready=0, arm(0,20), 21 beats -> level=16; overflow=1; done=1; head=first captured beat.
//  4. level=16, push and pop in the same cycle -> push accepted; level stays 16; overflow unchanged.
//  5. Mid-CAPTURE (3 of 8 stored): assert flush -> next cycle IDLE, level=0, out_valid=0; then arm(0,1) + trigger works normally.
//  6. rst=0 for 1 cycle during DELAY -> all outputs 0; arm with len=0 + trigger -> done=1, level=0.

Source files
------------

// File: rtl/adc_capture_buffer.sv
// -----------------------------------------------------------------------------
// adc_capture_buffer
//   Triggered capture stage for one ADC channel. After arm, the block waits for
//   trigger, skips delay_len valid beats, then pushes capture_len valid beats
//   into a first-word-fall-through FIFO that drains over a valid/ready port.
//
// Ports
//   clk          system clock (single domain)
//   rst          synchronous reset, active-low
//   adc_data_in  ADC beat (DATA_W bits, 8x16-bit samples)
//   adc_valid_in beat qualifier, no backpressure
//   arm          pulse: latch delay_len/capture_len, enter ARMED (IDLE/DONE only)
//   trigger      level, sampled only while ARMED
//   flush        pulse: abort capture, empty FIFO, clear overflow
//   delay_len    valid beats to skip after the trigger beat
//   capture_len  valid beats to capture
//   out_data     FIFO head, zero while empty
//   out_valid    FIFO not empty
//   out_ready    consumer pop request
//   busy         ARMED, DELAY or CAPTURE
//   done         DONE
//   overflow     sticky: a capture beat was dropped because the FIFO was full
//   level        FIFO occupancy (0..DEPTH)
// -----------------------------------------------------------------------------
module adc_capture_buffer #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          adc_data_in,
    input  logic                       adc_valid_in,
    input  logic                       arm,
    input  logic                       trigger,
    input  logic                       flush,
    input  logic [CNT_W-1:0]           delay_len,
    input  logic [CNT_W-1:0]           capture_len,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_DELAY   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   delay_lat;
    logic [CNT_W-1:0]   len_lat;
    logic               latch;
    logic               push;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               full;
    logic               pop;
    logic               push_ok;

    assign cnt_inc = cnt + CNT_W'(1);

    // Next-state, beat counter and push-attempt decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        push      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    latch     = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_ARMED;
                end else begin
                    state_nxt = state;
                end
            end
            ST_ARMED: begin
                // The beat present in the trigger cycle is never counted or stored.
                if (trigger) begin
                    cnt_nxt = '0;
                    if (delay_lat != '0) begin
                        state_nxt = ST_DELAY;
                    end else if (len_lat != '0) begin
                        state_nxt = ST_CAPTURE;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end else begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_DELAY: begin
                if (adc_valid_in) begin
                    if (cnt_inc == delay_lat) begin
                        cnt_nxt   = '0;
                        state_nxt = (len_lat != '0) ? ST_CAPTURE : ST_DONE;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else begin
                    cnt_nxt = cnt;
                end
            end
            ST_CAPTURE: begin
                // Every valid beat counts, even if the FIFO rejects it, so the
                // capture window is fixed regardless of consumer behaviour.
                if (adc_valid_in) begin
                    push = 1'b1;
                    if (cnt_inc == len_lat) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end else begin
                    cnt_nxt = cnt;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and latched length registers; flush aborts to IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            delay_lat <= '0;
            len_lat   <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            cnt       <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (latch) begin
                delay_lat <= delay_len;
                len_lat   <= capture_len;
            end
        end
    end

    assign full    = (level == LW'(DEPTH));
    assign pop     = out_valid & out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = push & (~full | pop);

    // FIFO storage; written only when a push is accepted and no flush/reset.
    always_ff @(posedge clk) begin
        if (rst && !flush && push_ok) begin
            mem[wr_ptr] <= adc_data_in;
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    assign out_valid = (level != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign busy      = (state == ST_ARMED) || (state == ST_DELAY) || (state == ST_CAPTURE);
    assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_adc_capture_buffer.sv
module tb_adc_capture_buffer;

    localparam int DATA_W = 128;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [DATA_W-1:0]     adc_data_in;
    logic                  adc_valid_in;
    logic                  arm;
    logic                  trigger;
    logic                  flush;
    logic [CNT_W-1:0]      delay_len;
    logic [CNT_W-1:0]      capture_len;
    logic [DATA_W-1:0]     out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [$clog2(DEPTH):0] level;

    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] exp_q [$];

    adc_capture_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .adc_data_in(adc_data_in), .adc_valid_in(adc_valid_in),
        .arm(arm), .trigger(trigger), .flush(flush),
        .delay_len(delay_len), .capture_len(capture_len),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .overflow(overflow), .level(level)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mk(input int i);
        logic [15:0] s;
        s = 16'(i);
        return {8{s}};
    endfunction

    function automatic void check(input string name, input logic [DATA_W-1:0] act,
                                  input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: every pop the DUT is about to perform is compared
    // with the oldest expected beat.
    always @(negedge clk) begin
        if (rst === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pop", out_data, '0);
                if (out_data === '0) begin
                    fails++;
                    $display("FAIL unexpected_pop: got pop with empty scoreboard, expected none");
                end
            end else begin
                check("pop_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int dl, input int cl);
        delay_len   = 16'(dl);
        capture_len = 16'(cl);
        arm         = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic do_trigger(input int d);
        trigger      = 1'b1;
        adc_valid_in = 1'b1;
        adc_data_in  = mk(d);
        step();
        trigger      = 1'b0;
        adc_valid_in = 1'b0;
    endtask

    task automatic beat(input int d);
        adc_valid_in = 1'b1;
        adc_data_in  = mk(d);
        step();
        adc_valid_in = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 40 && level != '0; k++) begin
            step();
        end
        out_ready = 1'b0;
        check("drain_level", 128'(level), 128'd0);
        check("drain_scoreboard_empty", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        rst = 1'b0; adc_data_in = '0; adc_valid_in = 1'b0; arm = 1'b0;
        trigger = 1'b0; flush = 1'b0; delay_len = '0; capture_len = '0;
        out_ready = 1'b0;
        step();
        step();
        check("rst_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_overflow", 128'(overflow), 128'd0);
        check("rst_level", 128'(level), 128'd0);
        check("rst_data", out_data, '0);
        rst = 1'b1;
        step();

        // Test 1: delay 0, length 4, streaming out
        out_ready = 1'b1;
        do_arm(0, 4);
        check("t1_busy_armed", 128'(busy), 128'd1);
        do_trigger(100);
        for (int i = 101; i <= 105; i++) begin
            if (i <= 104) exp_q.push_back(mk(i));
            beat(i);
        end
        check("t1_done", 128'(done), 128'd1);
        check("t1_busy", 128'(busy), 128'd0);
        check("t1_overflow", 128'(overflow), 128'd0);
        check("t1_level", 128'(level), 128'd0);
        check("t1_scoreboard_empty", 128'(exp_q.size()), 128'd0);
        out_ready = 1'b0;

        // Test 2: delay 3, length 2
        do_arm(3, 2);
        do_trigger(200);
        for (int i = 201; i <= 206; i++) begin
            if (i == 204 || i == 205) exp_q.push_back(mk(i));
            beat(i);
            if (i == 204) check("t2_busy_before", 128'(busy), 128'd1);
            if (i == 205) check("t2_busy_after", 128'(busy), 128'd0);
        end
        check("t2_level", 128'(level), 128'd2);
        check("t2_done", 128'(done), 128'd1);
        check("t2_head", out_data, mk(204));
        drain();

        // Test 3: overflow with length 20 into depth 16
        do_arm(0, 20);
        do_trigger(300);
        for (int i = 301; i <= 320; i++) begin
            if (i <= 316) exp_q.push_back(mk(i));
            beat(i);
        end
        check("t3_level", 128'(level), 128'd16);
        check("t3_overflow", 128'(overflow), 128'd1);
        check("t3_done", 128'(done), 128'd1);
        check("t3_head", out_data, mk(301));

        // Test 4: push and pop together while full
        do_arm(0, 1);
        do_trigger(400);
        out_ready = 1'b1;
        exp_q.push_back(mk(401));
        beat(401);
        out_ready = 1'b0;
        check("t4_level", 128'(level), 128'd16);
        check("t4_overflow", 128'(overflow), 128'd1);
        check("t4_done", 128'(done), 128'd1);
        check("t4_head", out_data, mk(302));
        drain();

        // Test 5: flush mid-capture, then a normal capture
        do_arm(0, 8);
        do_trigger(500);
        beat(501);
        beat(502);
        beat(503);
        check("t5_level_pre", 128'(level), 128'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t5_busy", 128'(busy), 128'd0);
        check("t5_done", 128'(done), 128'd0);
        check("t5_level", 128'(level), 128'd0);
        check("t5_valid", 128'(out_valid), 128'd0);
        check("t5_overflow", 128'(overflow), 128'd0);
        // flush and arm together: arm dropped
        flush = 1'b1;
        arm   = 1'b1;
        step();
        flush = 1'b0;
        arm   = 1'b0;
        check("t5_flush_arm_busy", 128'(busy), 128'd0);
        do_arm(0, 1);
        do_trigger(600);
        beat(601);
        check("t5_re_done", 128'(done), 128'd1);
        check("t5_re_level", 128'(level), 128'd1);
        check("t5_re_head", out_data, mk(601));

        // Test 6: reset during DELAY, then zero-length capture
        do_arm(5, 3);
        do_trigger(700);
        beat(701);
        beat(702);
        check("t6_busy_delay", 128'(busy), 128'd1);
        rst = 1'b0;
        step();
        check("t6_valid", 128'(out_valid), 128'd0);
        check("t6_busy", 128'(busy), 128'd0);
        check("t6_done", 128'(done), 128'd0);
        check("t6_level", 128'(level), 128'd0);
        check("t6_overflow", 128'(overflow), 128'd0);
        check("t6_data", out_data, '0);
        rst = 1'b1;
        do_arm(0, 0);
        do_trigger(800);
        check("t6_zero_done", 128'(done), 128'd1);
        check("t6_zero_level", 128'(level), 128'd0);
        check("t6_zero_busy", 128'(busy), 128'd0);
        check("final_scoreboard_empty", 128'(exp_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
